// File: rtl/mealy_run_end_detector_if.sv
// rtl/mealy_run_end_detector_if.sv - stream sample and detection bundle for mealy_run_end_detector
interface mealy_run_end_detector_if #(
  parameter int CNT_W = 4,
  parameter int DET_W = 8
);
  logic             clr;
  logic             x_valid;
  logic             x_in;
  logic [CNT_W-1:0] min_run;
  logic             y_out;
  logic [CNT_W-1:0] run_len;
  logic             run_len_valid;
  logic [DET_W-1:0] det_count;
  logic             run_sat;

  modport master (
    output clr, x_valid, x_in, min_run,
    input  y_out, run_len, run_len_valid, det_count, run_sat
  );

  modport slave (
    input  clr, x_valid, x_in, min_run,
    output y_out, run_len, run_len_valid, det_count, run_sat
  );
endinterface

// File: rtl/mealy_run_end_detector.sv
// rtl/mealy_run_end_detector.sv - run-end detector with run length and saturating detect count
// Optional MEALY_RUN_DET_REGOUT_EN: register y_out to drop the x_in-to-output path.
module mealy_run_end_detector #(
  parameter int   CNT_W   = 4,
  parameter int   DET_W   = 8,
  parameter logic RUN_BIT = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  mealy_run_end_detector_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SAT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [DET_W-1:0] DET_MAX = {DET_W{1'b1}};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] run_cnt, cnt_nxt;
  logic [CNT_W-1:0] run_len_q, run_len_nxt;
  logic [DET_W-1:0] det_q, det_nxt;
  logic [CNT_W-1:0] eff_min;
  logic             rlv_q;
  logic             det_hit;

  // A programmed minimum of zero would qualify empty runs, so it is floored to one.
  assign eff_min = (bus.min_run == '0) ? CNT_W'(1) : bus.min_run;
  assign det_hit = bus.x_valid & ~bus.clr & (bus.x_in != RUN_BIT) & (run_cnt >= eff_min);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = run_cnt;
    run_len_nxt = run_len_q;
    det_nxt     = det_q;
    if (bus.clr) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      run_len_nxt = '0;
      det_nxt     = '0;
    end else if (bus.x_valid) begin
      if (bus.x_in == RUN_BIT) begin
        if (state != SAT) begin
          cnt_nxt   = run_cnt + 1'b1;
          state_nxt = (cnt_nxt == CNT_MAX) ? SAT : RUN;
        end
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      if (det_hit) begin
        run_len_nxt = run_cnt;
        if (det_q != DET_MAX) begin
          det_nxt = det_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      run_cnt   <= '0;
      run_len_q <= '0;
      rlv_q     <= 1'b0;
      det_q     <= '0;
    end else begin
      state     <= state_nxt;
      run_cnt   <= cnt_nxt;
      run_len_q <= run_len_nxt;
      rlv_q     <= det_hit;
      det_q     <= det_nxt;
    end
  end

`ifdef MEALY_RUN_DET_REGOUT_EN
  logic y_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      y_q <= 1'b0;
    end else begin
      y_q <= det_hit;
    end
  end

  assign bus.y_out = y_q;
`else
  assign bus.y_out = det_hit;
`endif

  assign bus.run_len       = run_len_q;
  assign bus.run_len_valid = rlv_q;
  assign bus.det_count     = det_q;
  assign bus.run_sat       = (state == SAT);
endmodule

// File: tb/tb_mealy_run_end_detector.sv
// tb/tb_mealy_run_end_detector.sv - table-driven checks for mealy_run_end_detector
module tb_mealy_run_end_detector;
`ifdef MEALY_RUN_DET_REGOUT_EN
  localparam bit REGOUT = 1'b1;
`else
  localparam bit REGOUT = 1'b0;
`endif

  typedef struct {
    logic       clr;
    logic       xv;
    logic       x;
    logic [3:0] mr;
    logic       det;
    logic [3:0] rl;
    logic       rlv;
    logic [7:0] dc;
    logic       sat;
  } vec_t;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  logic prev_det;
  vec_t tbl[$];

  mealy_run_end_detector_if #(.CNT_W(4), .DET_W(8)) bus ();
  mealy_run_end_detector_if #(.CNT_W(4), .DET_W(2)) bus2 ();

  mealy_run_end_detector #(.CNT_W(4), .DET_W(8), .RUN_BIT(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  mealy_run_end_detector #(.CNT_W(4), .DET_W(2), .RUN_BIT(1'b1)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic add(input logic c, input logic v, input logic x, input int mr,
                     input logic det, input int rl, input logic rlv, input int dc, input logic sat);
    vec_t t;
    t.clr = c; t.xv = v; t.x = x; t.mr = 4'(mr);
    t.det = det; t.rl = 4'(rl); t.rlv = rlv; t.dc = 8'(dc); t.sat = sat;
    tbl.push_back(t);
  endtask

  task automatic apply(input vec_t t, input int idx);
    bus.clr = t.clr; bus.x_valid = t.xv; bus.x_in = t.x; bus.min_run = t.mr;
    @(negedge clock);
    chk($sformatf("v%0d_y", idx), int'(bus.y_out), int'(REGOUT ? prev_det : t.det));
    chk($sformatf("v%0d_run_len", idx), int'(bus.run_len), int'(t.rl));
    chk($sformatf("v%0d_rlv", idx), int'(bus.run_len_valid), int'(t.rlv));
    chk($sformatf("v%0d_det_count", idx), int'(bus.det_count), int'(t.dc));
    chk($sformatf("v%0d_run_sat", idx), int'(bus.run_sat), int'(t.sat));
    @(posedge clock);
    #1;
    prev_det = t.det;
  endtask

  initial begin
    checks = 0; failures = 0; prev_det = 1'b0;
    reset = 1'b0;
    bus.clr = 0; bus.x_valid = 0; bus.x_in = 0; bus.min_run = 4'd1;
    bus2.clr = 0; bus2.x_valid = 0; bus2.x_in = 0; bus2.min_run = 4'd1;

    //   clr xv x mr  det rl rlv dc sat
    add(0, 1, 0, 1,  0, 0, 0, 0, 0);
    add(0, 1, 1, 1,  0, 0, 0, 0, 0);
    add(0, 1, 1, 1,  0, 0, 0, 0, 0);
    add(0, 1, 1, 1,  0, 0, 0, 0, 0);
    add(0, 1, 0, 1,  1, 0, 0, 0, 0);
    add(0, 1, 0, 1,  0, 3, 1, 1, 0);
    add(1, 1, 0, 3,  0, 3, 0, 1, 0);
    add(0, 1, 1, 3,  0, 0, 0, 0, 0);
    add(0, 1, 1, 3,  0, 0, 0, 0, 0);
    add(0, 1, 0, 3,  0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 1, 3, 0, 0, 0, 0, 0);
    add(0, 1, 0, 3,  1, 0, 0, 0, 0);
    add(0, 1, 0, 3,  0, 4, 1, 1, 0);
    add(0, 1, 1, 1,  0, 4, 0, 1, 0);
    add(0, 1, 1, 1,  0, 4, 0, 1, 0);
    for (int i = 0; i < 5; i++) add(0, 0, logic'(i % 2), 1, 0, 4, 0, 1, 0);
    add(0, 1, 1, 1,  0, 4, 0, 1, 0);
    add(0, 1, 0, 1,  1, 4, 0, 1, 0);
    add(0, 1, 0, 1,  0, 3, 1, 2, 0);
    add(0, 1, 1, 1,  0, 3, 0, 2, 0);
    add(0, 1, 1, 1,  0, 3, 0, 2, 0);
    add(1, 1, 0, 1,  0, 3, 0, 2, 0);
    add(0, 1, 0, 1,  0, 0, 0, 0, 0);
    add(0, 1, 1, 0,  0, 0, 0, 0, 0);
    add(0, 1, 0, 0,  1, 0, 0, 0, 0);
    add(0, 1, 0, 0,  0, 1, 1, 1, 0);
    add(0, 1, 1, 5,  0, 1, 0, 1, 0);
    add(0, 1, 1, 5,  0, 1, 0, 1, 0);
    add(0, 1, 0, 2,  1, 1, 0, 1, 0);
    add(0, 1, 0, 2,  0, 2, 1, 2, 0);

    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i + 1);

    // Twenty ones into a 4-bit counter: saturated from the 15th one onward.
    bus.clr = 0; bus.x_valid = 1; bus.min_run = 4'd1;
    for (int k = 1; k <= 20; k++) begin
      bus.x_in = 1'b1;
      @(negedge clock);
      chk($sformatf("sat%0d_y", k), int'(bus.y_out), 0);
      @(posedge clock);
      #1;
      chk($sformatf("sat%0d_run_sat", k), int'(bus.run_sat), (k >= 15) ? 1 : 0);
    end
    bus.x_in = 1'b0;
    @(negedge clock);
    chk("sat_end_y", int'(bus.y_out), REGOUT ? 0 : 1);
    @(posedge clock);
    #1;
    chk("sat_end_run_len", int'(bus.run_len), 15);
    chk("sat_end_rlv", int'(bus.run_len_valid), 1);
    chk("sat_end_run_sat", int'(bus.run_sat), 0);
    chk("sat_end_det_count", int'(bus.det_count), 3);
    chk("sat_end_y_after", int'(bus.y_out), REGOUT ? 1 : 0);

    // Asynchronous reset between edges while a terminating bit is presented.
    bus.x_in = 1'b1;
    repeat (3) @(posedge clock);
    #1 bus.x_in = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("areset_y", int'(bus.y_out), 0);
    chk("areset_run_len", int'(bus.run_len), 0);
    chk("areset_rlv", int'(bus.run_len_valid), 0);
    chk("areset_det_count", int'(bus.det_count), 0);
    chk("areset_run_sat", int'(bus.run_sat), 0);
    bus.x_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;

    // Narrow detection counter saturates at 3.
    bus2.x_valid = 1'b1; bus2.min_run = 4'd1;
    for (int i = 1; i <= 5; i++) begin
      bus2.x_in = 1'b1;
      @(posedge clock);
      #1 bus2.x_in = 1'b0;
      @(posedge clock);
      #1;
      chk($sformatf("det2_%0d", i), int'(bus2.det_count), (i < 3) ? i : 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mealy_run_end_detector.md
Name: mealy_run_end_detector

Overview:
Parametrised successor of the single-bit Mealy zero detector. Watches a serial bit stream and asserts a combinational (Mealy) pulse when a run of RUN_BIT values of length >= min_run is terminated by the opposite bit. Also reports the terminated run length and a saturating detection count. Used in serial-link framing and line-code monitors in the sequential-circuits block set.

Parameters:
CNT_W, 4, width of run counter, min_run, run_len (max run tracked = 2^CNT_W-1)
DET_W, 8, width of saturating detection counter
RUN_BIT, 1'b1, bit value forming a run; the opposite value terminates it

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
clr  input  1  synchronous clear of state and counters
x_valid  input  1  x_in sample qualifier; no state change when 0
x_in  input  1  serial data bit
min_run  input  CNT_W  minimum run length that qualifies; 0 treated as 1
y_out  output  1  detection (Mealy, combinational from state and x_in)
run_len  output  CNT_W  length of last qualifying terminated run
run_len_valid  output  1  one-cycle pulse, cycle after a detection
det_count  output  DET_W  saturating count of detections
run_sat  output  1  high while run counter saturated (state SAT)

Behaviour:
- Reset (reset==0, async): state=IDLE, run_cnt=0, run_len=0, run_len_valid=0, det_count=0. y_out=0 because state is IDLE.
- Priority: reset > clr > x_valid. clr==1 at a rising edge gives the same register values as reset. y_out is forced to 0 in any cycle where clr==1.
- States:
  - IDLE: run_cnt==0.
  - RUN: 0 < run_cnt < max.
  - SAT: run_cnt == 2^CNT_W-1.
- Transitions (only when x_valid==1):
  - x_in==RUN_BIT: IDLE->RUN (cnt=1); RUN->RUN (cnt+1); RUN->SAT when cnt+1 == max; SAT->SAT (cnt holds).
  - x_in!=RUN_BIT: any state -> IDLE, cnt=0.
- x_valid==0: all registers hold; y_out=0.
- eff_min = (min_run==0) ? 1 : min_run. Sampled live each cycle; a change mid-run takes effect immediately.
- y_out = x_valid & ~clr & (x_in != RUN_BIT) & (run_cnt >= eff_min).
  - Zero latency: asserted in the same cycle as the terminating bit.
- On a clock edge with y_out==1:
  - run_len <= run_cnt.
  - run_len_valid <= 1 for exactly one cycle.
  - det_count <= det_count+1, saturating at 2^DET_W-1.
- Terminating bit with run_cnt < eff_min: state returns to IDLE; no y_out, no run_len update.
- Back-to-back runs: the terminating bit does not start a new run. The next RUN_BIT starts at cnt=1.
- Saturation: a run longer than the maximum reports run_len = 2^CNT_W-1. run_sat stays high until the run ends.
- Equivalence: with RUN_BIT=1 and min_run=1 (any CNT_W >= 2), y_out is bit-identical to the legacy zero detector.

Optional Feature:
MEALY_RUN_DET_REGOUT_EN
- Defined:
  - y_out is registered (Moore-style): it equals the combinational detect term delayed by one clock, and is reset to 0.
  - run_len_valid asserts in the same cycle as the registered y_out.
  - Removes the x_in-to-output combinational path for timing closure.
- Undefined: y_out is combinational as specified above.

Test Plan:
1. Defaults, min_run=1, x_valid=1, x_in=0,1,1,1,0,0 -> y_out=1 only on the 5th bit; run_len=3 with run_len_valid pulse next cycle; det_count=1; 6th bit gives y_out=0.
2. min_run=3, x_in=1,1,0,1,1,1,1,0 -> no detect on the 3rd bit; detect on the 8th bit; run_len=4; det_count=1.
3. CNT_W=4, twenty consecutive 1s then 0 -> run_sat high from the 15th 1 onward; detect on the 0; run_len=15; run_sat low after the terminating 0.
4. x_valid low for 5 cycles mid-run (x_in toggling) -> run_cnt unchanged and y_out=0 throughout; the run resumes and detection counts only valid bits.
5. Assert reset low asynchronously mid-run (between edges) -> all outputs 0 immediately. Separately, clr=1 coincident with a terminating 0 -> y_out=0; det_count and run_len cleared, not updated.
6. DET_W=2, five qualifying detections -> det_count sequence 1,2,3,3,3. Rebuild with MEALY_RUN_DET_REGOUT_EN -> y_out is the scenario-1 waveform delayed by one clock.
